// File: rtl/minirisc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : minirisc_pkg
// Description : Shared address width, reset PC and increment for KGPminiRISC.
// Revision    : 1.0
// ============================================================================
package minirisc_pkg;

    localparam int ADDR_W = 32;
    localparam int PC_INC = 1;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef logic [ADDR_W-1:0] addr_t;

endpackage : minirisc_pkg
`default_nettype wire

// File: rtl/branch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_unit_if
// Description : Jump-control and PC bundle between fetch logic and branch_unit.
// Revision    : 1.0
// ============================================================================
interface branch_unit_if;
    import minirisc_pkg::*;

    logic  JCout;
    logic  UncondJump;
    addr_t PCin;
    addr_t JumpAddr;
    addr_t PCnext;
    addr_t PCreg;

    modport master (
        output JCout,
        output UncondJump,
        output PCin,
        output JumpAddr,
        input  PCnext,
        input  PCreg
    );

    modport slave (
        input  JCout,
        input  UncondJump,
        input  PCin,
        input  JumpAddr,
        output PCnext,
        output PCreg
    );

endinterface : branch_unit_if
`default_nettype wire

// File: rtl/branch_unit_pc_incr.sv
`default_nettype none
// ============================================================================
// Module      : pc_incr
// Description : Sequential-PC adder; carry out is dropped so the PC wraps.
// Revision    : 1.0
// ============================================================================
module pc_incr #(
    parameter int WIDTH = minirisc_pkg::ADDR_W,
    parameter int INC   = minirisc_pkg::PC_INC
) (
    input  wire logic [WIDTH-1:0] pc,
    output logic      [WIDTH-1:0] pc_inc
);

    localparam logic [WIDTH-1:0] C_INC = WIDTH'(INC);

    assign pc_inc = pc + C_INC;

endmodule : pc_incr
`default_nettype wire

// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_unit
// Description : Next-PC select (sequential vs jump target) plus PC register.
// Revision    : 1.0
// ============================================================================
module branch_unit #(
    parameter int                                    ADDR_W   = minirisc_pkg::ADDR_W,
    parameter int                                    PC_INC   = minirisc_pkg::PC_INC,
    parameter logic [minirisc_pkg::ADDR_W-1:0]       RESET_PC = minirisc_pkg::RESET_PC
) (
    input  wire logic        clk,
    input  wire logic        rst,
    branch_unit_if.slave     bus
);

    logic              w_take;
    logic [ADDR_W-1:0] w_seq_pc;
    logic [ADDR_W-1:0] w_next_pc;
    logic [ADDR_W-1:0] r_pc;

    pc_incr #(
        .WIDTH (ADDR_W),
        .INC   (PC_INC)
    ) u_pc_incr (
        .pc     (bus.PCin),
        .pc_inc (w_seq_pc)
    );

    // Both jump sources share one target, so a simple OR resolves them.
    assign w_take    = bus.JCout | bus.UncondJump;
    assign w_next_pc = w_take ? bus.JumpAddr : w_seq_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= ADDR_W'(RESET_PC);
        end else begin
            r_pc <= w_next_pc;
        end
    end

    assign bus.PCnext = w_next_pc;
    assign bus.PCreg  = r_pc;

endmodule : branch_unit
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_unit
// Description : Directed-vector bench for branch_unit next-PC select and PC reg.
// Revision    : 1.0
// ============================================================================
module tb_branch_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    branch_unit_if bus ();

    branch_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive inputs on the falling edge, check PCnext, then PCreg after the next rising edge.
    task automatic step(input string tag, input logic jc, input logic uj,
                        input logic [31:0] pc, input logic [31:0] ja,
                        input logic [31:0] exp_next);
        @(negedge clk);
        bus.JCout      = jc;
        bus.UncondJump = uj;
        bus.PCin       = pc;
        bus.JumpAddr   = ja;
        #1;
        check({tag, "_next"}, bus.PCnext, exp_next);
        @(posedge clk);
        #1;
        check({tag, "_reg"}, bus.PCreg, exp_next);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        bus.JCout      = 1'b0;
        bus.UncondJump = 1'b0;
        bus.PCin       = 32'd2;
        bus.JumpAddr   = 32'd1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pcreg", bus.PCreg, 32'd0);
        check("reset_pcnext_live", bus.PCnext, 32'd3);

        @(negedge clk);
        rst = 1'b0;
        step("seq",      1'b0, 1'b0, 32'd2,          32'd1,          32'd3);
        step("jc",       1'b1, 1'b0, 32'd1,          32'd2,          32'd2);
        step("uj",       1'b0, 1'b1, 32'd5,          32'd10,         32'd10);
        step("both",     1'b1, 1'b1, 32'd0,          32'd1,          32'd1);
        step("wrap",     1'b0, 1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  32'd0);
        step("verbatim", 1'b0, 1'b1, 32'h0000_0040,  32'hDEAD_BEEF,  32'hDEAD_BEEF);
        step("seq_big",  1'b0, 1'b0, 32'h7FFF_FFFF,  32'h0000_0000,  32'h8000_0000);
        step("load7",    1'b0, 1'b0, 32'd6,          32'd100,        32'd7);

        // Reset raised between edges: PCreg must hold until the next rising edge.
        @(negedge clk);
        rst      = 1'b1;
        bus.PCin = 32'd10;
        #1;
        check("rst_hold_pcreg", bus.PCreg, 32'd7);
        check("rst_pcnext_live", bus.PCnext, 32'd11);
        @(posedge clk);
        #1;
        check("rst_apply_pcreg", bus.PCreg, 32'd0);
        bus.JCout    = 1'b1;
        bus.JumpAddr = 32'd55;
        #1;
        check("rst_pcnext_jump", bus.PCnext, 32'd55);
        @(posedge clk);
        #1;
        check("rst_held_pcreg", bus.PCreg, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 1'b0, 1'b0, 32'd0, 32'd9, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_branch_unit
`default_nettype wire

// File: doc/branch_unit.md
# branch_unit

Next-PC selection unit for the KGPminiRISC fetch stage. It chooses between the sequential successor of the current PC and a jump target, based on the conditional-jump resolution and the unconditional-jump decode. The selected value is available combinationally for the fetch path and is also held in an on-block PC register. Sits between the jump-condition logic / decoder and instruction memory.

## Interface
Parameters:
- `ADDR_W`, 32: PC and address width in bits.
- `PC_INC`, 1: sequential increment. Instruction memory is word-addressed, so +1 is one instruction.
- `RESET_PC`, 0: PC register value after reset.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `JCout`, in, 1: conditional-jump condition met (1 = take).
- `UncondJump`, in, 1: unconditional-jump instruction (1 = take).
- `PCin`, in, `ADDR_W`: current PC.
- `JumpAddr`, in, `ADDR_W`: jump target address.
- `PCnext`, out, `ADDR_W`: selected next PC (combinational).
- `PCreg`, out, `ADDR_W`: registered PC, loaded from `PCnext` each cycle.

## Operation
- `take = JCout | UncondJump`.
- When `take` is 1, `PCnext = JumpAddr`.
- When `take` is 0, `PCnext = PCin + PC_INC`.
- Arithmetic is unsigned, modulo 2^`ADDR_W`. A carry out is discarded, so `PCin` = all-ones with `PC_INC` = 1 gives 0. No overflow flag.
- `JCout` and `UncondJump` both 1: the jump is taken. Both request the same target, so there is no priority conflict.
- `JumpAddr` is used verbatim: no alignment, masking or sign extension.
- X/Z on `JCout` or `UncondJump` is not a legal input. Behaviour under X/Z is unspecified; the verification engineer flags it.

## Timing
- `PCnext` is purely combinational from `JCout`, `UncondJump`, `PCin` and `JumpAddr`. Zero-cycle latency, independent of `clk` and `rst`.
- `PCreg` updates on the rising edge of `clk`:
  - `rst` = 1 at the edge: `PCreg <= RESET_PC`.
  - Otherwise: `PCreg <= PCnext`.
- Reset value of `PCreg` is `RESET_PC` (0). `PCnext` has no reset value; it always follows its inputs.
- Reset asserted mid-operation takes effect only at the next rising edge. `PCreg` holds its value until then.
- Reset deasserted: `PCreg` takes `PCnext` at the first edge with `rst` = 0.
- No handshakes, no stalls, no multi-cycle paths.

## Structure
- Shared package `minirisc_pkg`:
  - `ADDR_W`;
  - `RESET_PC`;
  - `PC_INC`;
  - typedef `addr_t` (`ADDR_W`-bit logic).
- One natural sub-module, `pc_incr`: a parameterised `PCin + PC_INC` adder.
- The 2:1 mux and the PC register stay in the top level.

## Test plan
- `JCout=0`, `UncondJump=0`, `PCin=2`, `JumpAddr=1` -> `PCnext=3`; after one clock, `PCreg=3`.
- `JCout=1`, `UncondJump=0`, `PCin=1`, `JumpAddr=2` -> `PCnext=2`.
- `JCout=0`, `UncondJump=1`, `PCin=5`, `JumpAddr=10` -> `PCnext=10`.
- `JCout=1`, `UncondJump=1`, `PCin=0`, `JumpAddr=1` -> `PCnext=1`.
- Wrap-around: `JCout=0`, `UncondJump=0`, `PCin=32'hFFFF_FFFF` -> `PCnext=0`.
- Reset:
  - With `PCreg=7`, assert `rst` between edges: `PCreg` stays 7 until the edge, then becomes 0.
  - `PCnext` keeps tracking its inputs throughout.
  - Deassert `rst` with `PCin=0`, no jump: `PCreg=1` after the next edge.
